// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller: FSM state
// encoding, SRAM geometry and halfword-select helpers.
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  // Halfword select: HI carries req bits [31:16], LO carries [15:0]
  localparam logic HW_SEL_HI = 1'b0;
  localparam logic HW_SEL_LO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_RESP = 2'd3
  } sram_state_e;

  function automatic logic [SRAM_AW-1:0] hw_addr(input logic [18:0] word, input logic sel);
    return {word, sel};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bus of the SRAM controller; the requester uses master,
// the controller uses slave.
interface sram_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter: count 0 is the setup cycle, 1..WAIT_CYCLES are
// strobe cycles; the count saturates at WAIT_CYCLES and reloads on load.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic setup,
  output logic strobe,
  output logic last
);

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [3:0] cnt_r;

  // Counter: reload on phase entry, advance while in a phase, never wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= 4'd0;
    end else if (run && (cnt_r != WAIT_L)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign setup  = (cnt_r == 4'd0);
  assign strobe = (cnt_r != 4'd0);
  assign last   = (cnt_r == WAIT_L);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit request port to a 16-bit asynchronous SRAM, two halfword phases per
// access. Define SRAM_CTRL_SKIP_EN to skip store phases with no byte enables.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  sram_ctrl_if.slave         bus,
  output logic [SRAM_AW-1:0] sram_a,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  sram_state_e        state_r, state_nxt_s;
  logic               we_r;
  logic [18:0]        word_r;
  logic [31:0]        wdata_r;
  logic [3:0]         be_r;
  logic [31:0]        rdata_r;
  logic               ready_r, rsp_valid_r;
  logic [SRAM_AW-1:0] sram_a_r;
  logic               ce_n_r, we_n_r, oe_n_r, lb_n_r, ub_n_r, dq_oe_r;
  logic [SRAM_DW-1:0] dq_out_r;

  logic               accept_s, phase_s, phase_done_s, load_s;
  logic               t_strobe_s, t_last_s, setup_unused_s;
  logic               op_we_s;
  logic [18:0]        op_word_s;
  logic [31:0]        op_wdata_s;
  logic [3:0]         op_be_s;
  logic               skip_hi_s, skip_lo_s;
  logic               nxt_phase_s, nxt_strobe_s, nxt_sel_s;
  logic [1:0]         nxt_be_s;
  logic [SRAM_DW-1:0] nxt_hw_s;
  logic               addr_unused_s;

  assign accept_s      = bus.req_valid && ready_r;
  assign phase_s       = (state_r == ST_HI) || (state_r == ST_LO);
  assign phase_done_s  = phase_s && t_last_s;
  assign addr_unused_s = ^{bus.req_addr[31:21], bus.req_addr[1:0]};

  // The decode for the accept edge must see the incoming request, not the stale registers
  assign op_we_s    = accept_s ? bus.req_we          : we_r;
  assign op_word_s  = accept_s ? bus.req_addr[20:2]  : word_r;
  assign op_wdata_s = accept_s ? bus.req_wdata       : wdata_r;
  assign op_be_s    = accept_s ? bus.req_be          : be_r;

`ifdef SRAM_CTRL_SKIP_EN
  assign skip_hi_s = op_we_s && (op_be_s[3:2] == 2'b00);
  assign skip_lo_s = op_we_s && (op_be_s[1:0] == 2'b00);
`else
  assign skip_hi_s = 1'b0;
  assign skip_lo_s = 1'b0;
`endif

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .run    (phase_s),
    .setup  (setup_unused_s),
    .strobe (t_strobe_s),
    .last   (t_last_s)
  );

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s)       state_nxt_s = ST_IDLE;
        else if (!skip_hi_s) state_nxt_s = ST_HI;
        else if (!skip_lo_s) state_nxt_s = ST_LO;
        else                 state_nxt_s = ST_RESP;
      end
      ST_HI:   state_nxt_s = phase_done_s ? (skip_lo_s ? ST_RESP : ST_LO) : ST_HI;
      ST_LO:   state_nxt_s = phase_done_s ? ST_RESP : ST_LO;
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pin decode for the coming cycle, so every SRAM pin leaves a flop
  always_comb begin
    nxt_phase_s  = (state_nxt_s == ST_HI) || (state_nxt_s == ST_LO);
    load_s       = nxt_phase_s && (state_nxt_s != state_r);
    nxt_strobe_s = nxt_phase_s && !load_s;
    nxt_sel_s    = (state_nxt_s == ST_LO) ? HW_SEL_LO : HW_SEL_HI;
    nxt_hw_s     = (nxt_sel_s == HW_SEL_LO) ? op_wdata_s[15:0] : op_wdata_s[31:16];
    nxt_be_s     = (nxt_sel_s == HW_SEL_LO) ? op_be_s[1:0]     : op_be_s[3:2];
  end

  // FSM state, request capture and load-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      word_r  <= 19'd0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        we_r    <= bus.req_we;
        word_r  <= bus.req_addr[20:2];
        wdata_r <= bus.req_wdata;
        be_r    <= bus.req_be;
      end
      // dq_in is sampled at the end of the final strobe cycle of a load phase
      if (phase_done_s && !we_r && t_strobe_s) begin
        if (state_r == ST_HI) rdata_r[31:16] <= sram_dq_in;
        else                  rdata_r[15:0]  <= sram_dq_in;
      end
    end
  end

  // Registered SRAM pins and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      sram_a_r    <= '0;
      ce_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      lb_n_r      <= 1'b1;
      ub_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= '0;
    end else begin
      ready_r     <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      sram_a_r    <= nxt_phase_s ? hw_addr(op_word_s, nxt_sel_s) : sram_a_r;
      ce_n_r      <= !nxt_phase_s;
      we_n_r      <= !(nxt_strobe_s && op_we_s);
      oe_n_r      <= !(nxt_strobe_s && !op_we_s);
      lb_n_r      <= nxt_strobe_s ? (op_we_s ? !nxt_be_s[0] : 1'b0) : 1'b1;
      ub_n_r      <= nxt_strobe_s ? (op_we_s ? !nxt_be_s[1] : 1'b0) : 1'b1;
      dq_oe_r     <= nxt_phase_s && op_we_s;
      dq_out_r    <= (nxt_phase_s && op_we_s) ? nxt_hw_s : dq_out_r;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign sram_a        = sram_a_r;
  assign sram_ce_n     = ce_n_r;
  assign sram_we_n     = we_n_r;
  assign sram_oe_n     = oe_n_r;
  assign sram_lb_n     = lb_n_r;
  assign sram_ub_n     = ub_n_r;
  assign sram_dq_out   = dq_out_r;
  assign sram_dq_oe    = dq_oe_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a default-timing instance against a small
// SRAM model and a WAIT_CYCLES=3 instance against an address-derived pattern.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  sram_ctrl_if bus();
  sram_ctrl_if bus3();

  logic [19:0] sram_a, a3;
  logic        ce_n, we_n, oe_n, lb_n, ub_n, dq_oe;
  logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n, dq_oe3;
  logic [15:0] dq_out, dq_in, dq_out3, dq_in3;

  sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sram_a(sram_a), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
    .sram_lb_n(lb_n), .sram_ub_n(ub_n), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_dq_in(dq_in)
  );

  sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .sram_a(a3), .sram_ce_n(ce3_n), .sram_we_n(we3_n), .sram_oe_n(oe3_n),
    .sram_lb_n(lb3_n), .sram_ub_n(ub3_n), .sram_dq_out(dq_out3),
    .sram_dq_oe(dq_oe3), .sram_dq_in(dq_in3)
  );

`ifdef SRAM_CTRL_SKIP_EN
  localparam int LAT_BE2 = 3;
  localparam int LAT_BE0 = 1;
`else
  localparam int LAT_BE2 = 5;
  localparam int LAT_BE0 = 5;
`endif

  // SRAM model, aliased on the low 12 halfword-address bits
  logic [15:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = 12'd0;
  logic [15:0] pre_data = 16'd0;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_a[11:0]][7:0]  <= dq_out[7:0];
      if (!ub_n) mem[sram_a[11:0]][15:8] <= dq_out[15:8];
    end
  end

  assign dq_in  = oe_n  ? 16'h0000 : mem[sram_a[11:0]];
  assign dq_in3 = oe3_n ? 16'h0000 : (a3[15:0] ^ 16'hA5A5);

  // Protocol monitors sampled mid-cycle
  logic        overlap_seen = 1'b0;
  int          lb_wr_cnt = 0;
  int          rsp_cnt = 0;
  int          oe3_run = 0, oe3_max = 0, oe3_total = 0;
  logic [19:0] last_rd_a = 20'd0;

  always @(negedge clk) begin
    if ((!oe_n && dq_oe) || (!oe3_n && dq_oe3)) overlap_seen <= 1'b1;
    if (!we_n && !lb_n) lb_wr_cnt <= lb_wr_cnt + 1;
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (!oe_n) last_rd_a <= sram_a;
    if (!oe3_n) begin
      oe3_run   <= oe3_run + 1;
      oe3_total <= oe3_total + 1;
      if (oe3_run + 1 > oe3_max) oe3_max <= oe3_run + 1;
    end else begin
      oe3_run <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // One request on the default instance; lat counts cycles from accept to rsp_valid
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat, output logic [31:0] rdata);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_val("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    rdata = bus.rsp_rdata;
  endtask

  int          lat;
  int          snap;
  int          guard;
  logic [31:0] rd;

  initial begin
    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = 32'd0;
    bus.req_wdata  = 32'd0; bus.req_be = 4'd0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = 32'd0;
    bus3.req_wdata = 32'd0; bus3.req_be = 4'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_val("rst_ready",   32'(bus.req_ready), 32'd1);
    check_val("rst_rsp",     32'(bus.rsp_valid), 32'd0);
    check_val("rst_rdata",   bus.rsp_rdata, 32'd0);
    check_val("rst_addr",    32'(sram_a), 32'd0);
    check_val("rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    check_val("rst_dq_oe",   32'(dq_oe), 32'd0);
    check_val("rst_dq_out",  32'(dq_out), 32'd0);

    // 0x000C0060: word 0x30018 -> halfwords 0x60030 (HI) / 0x60031 (LO)
    preload(12'h030, 16'hDEAD);
    preload(12'h031, 16'hBEEF);
    run_req(1'b0, 32'h000C0060, 32'd0, 4'h0, lat, rd);
    check_val("load_lat",   32'(lat), 32'd5);
    check_val("load_rdata", rd, 32'hDEADBEEF);
    check_val("load_lo_a",  32'(last_rd_a), 32'h60031);

    run_req(1'b1, 32'h00000100, 32'h12345678, 4'hF, lat, rd);
    check_val("st_lat",      32'(lat), 32'd5);
    check_val("st_hw80",     32'(mem[12'h080]), 32'h1234);
    check_val("st_hw81",     32'(mem[12'h081]), 32'h5678);
    check_val("st_rdata_kept", rd, 32'hDEADBEEF);
    run_req(1'b0, 32'h00000100, 32'd0, 4'h0, lat, rd);
    check_val("rb_lat",   32'(lat), 32'd5);
    check_val("rb_rdata", rd, 32'h12345678);

    // be=0x2 touches only dq[15:8] of halfword 0x101
    preload(12'h100, 16'h2222);
    preload(12'h101, 16'h1111);
    snap = lb_wr_cnt;
    run_req(1'b1, 32'h00000200, 32'hAABBCCDD, 4'h2, lat, rd);
    check_val("be2_lat",   32'(lat), 32'(LAT_BE2));
    check_val("be2_hw100", 32'(mem[12'h100]), 32'h2222);
    check_val("be2_hw101", 32'(mem[12'h101]), 32'hCC11);
    check_val("be2_lb_off", 32'(lb_wr_cnt - snap), 32'd0);

    preload(12'h200, 16'h3333);
    preload(12'h201, 16'h4444);
    run_req(1'b1, 32'h00000400, 32'hFFFFFFFF, 4'h0, lat, rd);
    check_val("be0_lat",   32'(lat), 32'(LAT_BE0));
    check_val("be0_hw200", 32'(mem[12'h200]), 32'h3333);
    check_val("be0_hw201", 32'(mem[12'h201]), 32'h4444);

    // Back-to-back loads with req_valid held high throughout
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h00000100;
    check_val("b2b_ready0", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_addr = 32'h000C0060;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 50);
    check_val("b2b_lat1",   32'(lat), 32'd5);
    check_val("b2b_rdata1", bus.rsp_rdata, 32'h12345678);
    @(negedge clk);
    check_val("b2b_ready_after_resp", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 50);
    check_val("b2b_lat2",   32'(lat), 32'd5);
    check_val("b2b_rdata2", bus.rsp_rdata, 32'hDEADBEEF);

    // Reset during the LO write strobe
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h00000300;
    bus.req_wdata = 32'h0BADF00D; bus.req_be = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(!we_n && sram_a[0]) && guard < 20);
    check_val("rst_mid_reached_lo", 32'(!we_n && sram_a[0]), 32'd1);
    snap  = rsp_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_mid_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    check_val("rst_mid_dq_oe",   32'(dq_oe), 32'd0);
    check_val("rst_mid_rsp",     32'(bus.rsp_valid), 32'd0);
    check_val("rst_mid_ready",   32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_mid_no_rsp", 32'(rsp_cnt - snap), 32'd0);

    // WAIT_CYCLES=3: halfwords 0x20/0x21 -> 0xA585 / 0xA584
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 32'h00000040;
    guard = 0;
    while (!bus3.req_ready && guard < 50) begin @(negedge clk); guard++; end
    check_val("w3_accept", 32'(bus3.req_ready), 32'd1);
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus3.rsp_valid && lat < 50);
    check_val("w3_lat",       32'(lat), 32'd9);
    check_val("w3_rdata",     bus3.rsp_rdata, 32'hA585A584);
    check_val("w3_strobe_len", 32'(oe3_max), 32'd3);
    check_val("w3_strobe_tot", 32'(oe3_total), 32'd6);

    check_val("oe_dq_oe_overlap", 32'(overlap_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
